// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the 640x480@60 raster and the 10-bit
// coordinate type used by the timing generator and its consumers.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_H_VIS   = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_VIS   = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BP    = 33;

    localparam int DEF_H_TOTAL    = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL    = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START   = DEF_H_VIS + DEF_H_FP;
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START   = DEF_V_VIS + DEF_V_FP;
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

    // Half-open window test: lo <= v < hi, all unsigned 10-bit.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-rate divider: counts system clocks while enabled and emits a
// one-clock tick on the last clock of each pixel period.
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             w_last;

    // With CLK_DIV=1 the counter stays at zero, so every enabled clock is a tick.
    assign w_last = (r_div == DIV_W'(CLK_DIV - 1));
    assign o_tick = i_en && w_last;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (i_en) begin
            r_div <= w_last ? '0 : r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync and blanking decode,
// and a fully registered, mutually aligned output set updated once per pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               pix_tick,
    output logic               line_end,
    output logic               frame_end,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
        $error("vga_timing_gen: timing sums exceed the 10-bit coordinate range");
    end

    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_C = coord_t'(H_VIS);
    localparam coord_t V_VIS_C = coord_t'(V_VIS);
    localparam coord_t HS_LO   = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_HI   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_LO   = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_HI   = coord_t'(V_VIS + V_FP + V_SYNC);

    logic   w_tick;
    logic   w_h_last;
    logic   w_v_last;
    coord_t r_hcnt;
    coord_t r_vcnt;
    coord_t r_xpos;
    coord_t r_ypos;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_video_on;
    logic   r_pix_tick;
    logic   r_line_end;
    logic   r_frame_end;
    logic [7:0] r_frame_count;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (en),
        .o_tick (w_tick)
    );

    assign w_h_last = (r_hcnt == H_LAST);
    assign w_v_last = (r_vcnt == V_LAST);

    // Outputs describe the pixel the counters point at before this tick advances them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_xpos        <= '0;
            r_ypos        <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_pix_tick    <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_pix_tick  <= w_tick;
            r_line_end  <= w_tick && w_h_last;
            r_frame_end <= w_tick && w_h_last && w_v_last;
            if (w_tick) begin
                r_xpos     <= r_hcnt;
                r_ypos     <= r_vcnt;
                r_hsync    <= in_window(r_hcnt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
                r_vsync    <= in_window(r_vcnt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
                r_video_on <= (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
                r_hcnt     <= w_h_last ? '0 : r_hcnt + coord_t'(1);
                if (w_h_last) begin
                    r_vcnt <= w_v_last ? '0 : r_vcnt + coord_t'(1);
                    if (w_v_last) begin
                        r_frame_count <= r_frame_count + 8'd1;
                    end
                end
            end
        end
    end

    assign xpos        = r_xpos;
    assign ypos        = r_ypos;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pix_tick    = r_pix_tick;
    assign line_end    = r_line_end;
    assign frame_end   = r_frame_end;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance for line-level timing, enable
// hold and async reset, plus a tiny-raster instance for frame and counter wrap.
module tb_vga_timing_gen;

    typedef struct {
        int cyc;
        int x;
        int y;
        bit hs;
        bit vs;
        bit vo;
        bit le;
        bit fe;
        int fc;
    } exp_t;

    exp_t q_big[$];
    exp_t q_small[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Default-timing instance (CLK_DIV=2, 800x525)
    logic       b_rst = 1'b1;
    logic       b_en  = 1'b0;
    logic [9:0] b_x, b_y;
    logic       b_hs, b_vs, b_vo, b_pt, b_le, b_fe;
    logic [7:0] b_fc;

    vga_timing_gen #(
        .CLK_DIV (2)
    ) u_big (
        .clk         (clk),
        .rst         (b_rst),
        .en          (b_en),
        .xpos        (b_x),
        .ypos        (b_y),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .video_on    (b_vo),
        .pix_tick    (b_pt),
        .line_end    (b_le),
        .frame_end   (b_fe),
        .frame_count (b_fc)
    );

    // Tiny raster: 15x10 total, hsync x=10..12, vsync y=7..8, CLK_DIV=1
    logic       s_rst = 1'b1;
    logic       s_en  = 1'b0;
    logic [9:0] s_x, s_y;
    logic       s_hs, s_vs, s_vo, s_pt, s_le, s_fe;
    logic [7:0] s_fc;

    vga_timing_gen #(
        .CLK_DIV  (1),
        .H_VIS    (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_VIS    (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b0)
    ) u_small (
        .clk         (clk),
        .rst         (s_rst),
        .en          (s_en),
        .xpos        (s_x),
        .ypos        (s_y),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .video_on    (s_vo),
        .pix_tick    (s_pt),
        .line_end    (s_le),
        .frame_end   (s_fe),
        .frame_count (s_fc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs for the k-th pixel after reset, from the raster definition.
    function automatic exp_t big_exp(input int k, input int c);
        exp_t e;
        e.cyc = c;
        e.x   = k % 800;
        e.y   = (k / 800) % 525;
        e.hs  = !(e.x >= 656 && e.x <= 751);
        e.vs  = !(e.y >= 490 && e.y <= 491);
        e.vo  = (e.x < 640) && (e.y < 480);
        e.le  = (e.x == 799);
        e.fe  = e.le && (e.y == 524);
        e.fc  = ((k + 1) / 420000) % 256;
        return e;
    endfunction

    function automatic exp_t small_exp(input int k, input int c);
        exp_t e;
        e.cyc = c;
        e.x   = k % 15;
        e.y   = (k / 15) % 10;
        e.hs  = !(e.x >= 10 && e.x <= 12);
        e.vs  = !(e.y >= 7 && e.y <= 8);
        e.vo  = (e.x < 8) && (e.y < 6);
        e.le  = (e.x == 14);
        e.fe  = e.le && (e.y == 9);
        e.fc  = ((k + 1) / 150) % 256;
        return e;
    endfunction

    task automatic cmp_tick(input string tag, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                            input logic hs, input logic vs, input logic vo, input logic le,
                            input logic fe, input logic [7:0] fc);
        check({tag, "_tick_cycle"}, cyc, e.cyc);
        check({tag, "_xpos"}, x, e.x);
        check({tag, "_ypos"}, y, e.y);
        check({tag, "_hsync"}, hs, e.hs);
        check({tag, "_vsync"}, vs, e.vs);
        check({tag, "_video_on"}, vo, e.vo);
        check({tag, "_line_end"}, le, e.le);
        check({tag, "_frame_end"}, fe, e.fe);
        check({tag, "_frame_count"}, fc, e.fc);
    endtask

    task automatic check_reset_outputs(input string tag, input logic [9:0] x, input logic [9:0] y,
                                       input logic hs, input logic vs, input logic vo, input logic pt,
                                       input logic le, input logic fe, input logic [7:0] fc);
        check({tag, "_xpos"}, x, 0);
        check({tag, "_ypos"}, y, 0);
        check({tag, "_hsync"}, hs, 1);
        check({tag, "_vsync"}, vs, 1);
        check({tag, "_video_on"}, vo, 0);
        check({tag, "_pix_tick"}, pt, 0);
        check({tag, "_line_end"}, le, 0);
        check({tag, "_frame_end"}, fe, 0);
        check({tag, "_frame_count"}, fc, 0);
    endtask

    // Monitors: pop and compare on every pix_tick; strobes must never appear without it.
    always @(negedge clk) begin : mon_big
        exp_t e;
        if (b_pt === 1'b1) begin
            if (q_big.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL big_unexpected_tick: pix_tick=1 at xpos=%0d ypos=%0d, expected none (cycle %0d)", b_x, b_y, cyc);
            end else begin
                e = q_big.pop_front();
                cmp_tick("big", e, b_x, b_y, b_hs, b_vs, b_vo, b_le, b_fe, b_fc);
            end
        end else begin
            check("big_strobe_without_tick", {b_le, b_fe}, 0);
        end
    end

    always @(negedge clk) begin : mon_small
        exp_t e;
        if (s_pt === 1'b1) begin
            if (q_small.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL small_unexpected_tick: pix_tick=1 at xpos=%0d ypos=%0d, expected none (cycle %0d)", s_x, s_y, cyc);
            end else begin
                e = q_small.pop_front();
                cmp_tick("small", e, s_x, s_y, s_hs, s_vs, s_vo, s_le, s_fe, s_fc);
            end
        end else begin
            check("small_strobe_without_tick", {s_le, s_fe}, 0);
        end
    end

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic run_big();
        int r;
        int t;
        int last;
        repeat (3) @(negedge clk);
        check_reset_outputs("big_reset", b_x, b_y, b_hs, b_vs, b_vo, b_pt, b_le, b_fe, b_fc);

        // Release during cycle r (clk 1); first tick loads at edge r+2, visible in clk 3.
        b_rst = 1'b0;
        b_en  = 1'b1;
        r     = cyc;
        for (int k = 0; k <= 300; k++) q_big.push_back(big_exp(k, r + 2 + 2 * k));
        wait_cycle(r + 2 + 600);

        // Freeze for 7 clocks right after the xpos=300 pixel is presented.
        b_en = 1'b0;
        t    = cyc;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("big_hold_pix_tick", b_pt, 0);
            check("big_hold_xpos", b_x, 300);
            check("big_hold_video_on", b_vo, 1);
        end
        b_en = 1'b1;
        for (int k = 301; k <= 1500; k++) q_big.push_back(big_exp(k, t + 9 + 2 * (k - 301)));
        last = t + 9 + 2 * (1500 - 301);
        wait_cycle(last);

        // xpos=700, ypos=1 is inside hsync: reset mid-cycle, away from any clock edge.
        #2;
        b_rst = 1'b1;
        #1;
        check_reset_outputs("big_async_reset", b_x, b_y, b_hs, b_vs, b_vo, b_pt, b_le, b_fe, b_fc);
        check("big_queue_drained_before_reset", q_big.size(), 0);
        repeat (2) @(negedge clk);

        b_rst = 1'b0;
        r     = cyc;
        for (int k = 0; k < 10; k++) q_big.push_back(big_exp(k, r + 2 + 2 * k));
        wait_cycle(r + 2 + 18);
        b_en = 1'b0;
        repeat (4) @(negedge clk);
        check("big_queue_drained_after_restart", q_big.size(), 0);
    endtask

    task automatic run_small();
        int r;
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("small_reset", s_x, s_y, s_hs, s_vs, s_vo, s_pt, s_le, s_fe, s_fc);

        // 256 frames of 150 pixels, plus a few pixels past the frame_count wrap.
        s_rst = 1'b0;
        s_en  = 1'b1;
        r     = cyc;
        n     = 256 * 150 + 5;
        for (int k = 0; k < n; k++) q_small.push_back(small_exp(k, r + 1 + k));
        wait_cycle(r + n);
        s_en = 1'b0;
        repeat (3) @(negedge clk);
        check("small_queue_drained", q_small.size(), 0);
        check("small_frame_count_after_wrap", s_fc, 0);
    endtask

    initial begin
        fork
            run_big();
            run_small();
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
